// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit beside the main ALU.
// Owns the HI/LO pair, decodes the MDU funct codes, and runs a
// shift-add multiply or a restoring shift-subtract divide over WIDTH+1 cycles.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam logic [CNTW-1:0]  CNT_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) f_mag = W_ZERO - v;
    else                   f_mag = v;
  endfunction

  // Conditional two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) f_cneg = W_ZERO - v;
    else     f_cneg = v;
  endfunction

  state_t                 state_r, state_nx_s;
  logic [CNTW-1:0]        cnt_r;
  logic                   op_div_r;
  logic                   neg_q_r;     // product / quotient is negative
  logic                   neg_r_r;     // dividend was negative (remainder sign)
  logic [WIDTH-1:0]       a_mag_r;
  logic [WIDTH-1:0]       b_mag_r;
  logic [WIDTH-1:0]       acc_hi_r;
  logic [WIDTH-1:0]       acc_lo_r;
  logic [WIDTH-1:0]       hi_r, lo_r;
  logic                   done_r;

  logic                   is_muldiv_s;
  logic                   is_mdu_s;
  logic                   is_signed_s;
  logic [WIDTH:0]         mul_sum_s;
  logic [WIDTH:0]         div_shift_s;
  logic [WIDTH:0]         div_diff_s;
  logic                   div_ok_s;
  logic [2*WIDTH-1:0]     prod_fix_s;
  logic [WIDTH-1:0]       fix_hi_s, fix_lo_s;

  assign hi    = hi_r;
  assign lo    = lo_r;
  assign done  = done_r;
  assign busy  = (state_r != S_IDLE);
  assign stall = start & busy & is_mdu_s;

  // Decode of the funct field: mult/div group and the whole MDU group.
  always_comb begin
    is_muldiv_s = 1'b0;
    is_mdu_s    = 1'b0;
    is_signed_s = 1'b0;
    case (funct)
      F_MULT, F_DIV: begin
        is_muldiv_s = 1'b1;
        is_mdu_s    = 1'b1;
        is_signed_s = 1'b1;
      end
      F_MULTU, F_DIVU: begin
        is_muldiv_s = 1'b1;
        is_mdu_s    = 1'b1;
      end
      F_MFHI, F_MTHI, F_MFLO, F_MTLO: begin
        is_mdu_s = 1'b1;
      end
      default: begin
        is_mdu_s = 1'b0;
      end
    endcase
  end

  // Read port: mfhi/mflo return HI/LO, anything else drives zero.
  always_comb begin
    result = W_ZERO;
    if (start) begin
      case (funct)
        F_MFHI:  result = hi_r;
        F_MFLO:  result = lo_r;
        default: result = W_ZERO;
      endcase
    end else begin
      result = W_ZERO;
    end
  end

  // One iteration step of each algorithm plus the final sign fix-up.
  always_comb begin
    // Shift-add: conditionally add multiplicand into the upper half, then shift right.
    if (acc_lo_r[0]) mul_sum_s = {1'b0, acc_hi_r} + {1'b0, a_mag_r};
    else             mul_sum_s = {1'b0, acc_hi_r};
    // Restoring divide: shift next dividend bit into the remainder and trial-subtract.
    div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, b_mag_r};
    div_ok_s    = ~div_diff_s[WIDTH];
    // Sign fix-up; -2^(W-1)/-1 falls out naturally as quotient 2^(W-1), remainder 0.
    if (neg_q_r) prod_fix_s = {(2*WIDTH){1'b0}} - {acc_hi_r, acc_lo_r};
    else         prod_fix_s = {acc_hi_r, acc_lo_r};
    if (!op_div_r) begin
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_fix_s[WIDTH-1:0];
    end else if (b_mag_r == W_ZERO) begin
      // Divide by zero: quotient all ones, remainder is the original dividend.
      fix_hi_s = f_cneg(a_mag_r, neg_r_r);
      fix_lo_s = W_ONES;
    end else begin
      fix_hi_s = f_cneg(acc_hi_r, neg_r_r);
      fix_lo_s = f_cneg(acc_lo_r, neg_q_r);
    end
  end

  // Next-state logic for IDLE -> CALC -> FIX -> IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start && is_muldiv_s) state_nx_s = S_CALC;
        else                      state_nx_s = S_IDLE;
      end
      S_CALC: begin
        if (cnt_r == CNT_LAST) state_nx_s = S_FIX;
        else                   state_nx_s = S_CALC;
      end
      S_FIX:   state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_nx_s;
  end

  // Datapath: operand capture, iteration, HI/LO writes and done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r    <= CNT_ZERO;
      op_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      a_mag_r  <= W_ZERO;
      b_mag_r  <= W_ZERO;
      acc_hi_r <= W_ZERO;
      acc_lo_r <= W_ZERO;
      hi_r     <= W_ZERO;
      lo_r     <= W_ZERO;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start && is_muldiv_s) begin
            cnt_r    <= CNT_ZERO;
            op_div_r <= funct[1];
            neg_q_r  <= is_signed_s & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_r_r  <= is_signed_s & funct[1] & srca[WIDTH-1];
            a_mag_r  <= f_mag(srca, is_signed_s);
            b_mag_r  <= f_mag(srcb, is_signed_s);
            acc_hi_r <= W_ZERO;
            // Multiply shifts the multiplier out of LO; divide shifts the dividend out.
            acc_lo_r <= funct[1] ? f_mag(srca, is_signed_s) : f_mag(srcb, is_signed_s);
          end else if (start && funct == F_MTHI) begin
            hi_r <= srca;
          end else if (start && funct == F_MTLO) begin
            lo_r <= srca;
          end
        end
        S_CALC: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (op_div_r) begin
            acc_hi_r <= div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            acc_lo_r <= {acc_lo_r[WIDTH-2:0], div_ok_s};
          end else begin
            acc_hi_r <= mul_sum_s[WIDTH:1];
            acc_lo_r <= {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          hi_r   <= fix_hi_s;
          lo_r   <= fix_lo_s;
          done_r <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed HI/LO results for muldiv_unit.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] srca, srcb;
  logic [W-1:0] result, hi, lo;
  logic         busy, stall, done;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .srca(srca), .srcb(srcb), .result(result), .busy(busy),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge, then drop start.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; funct = f; srca = a; srcb = b;
    tick();
    start = 1'b0; funct = 6'd0;
  endtask

  // Count cycles until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Full mult/div check: latency, done pulse, HI/LO values.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    issue(f, a, b);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_idle(n);
    chk({tag, "_cycles"}, 64'(n), 64'd33);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(lo), 64'(elo));
    tick();
    chk({tag, "_done_off"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int saw_done;
    reset = 1'b0; start = 1'b0; funct = 6'd0; srca = '0; srcb = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    start = 1'b1; funct = F_MFHI; #1;
    chk("rst_result", 64'(result), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();

    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m3x7", F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_nn",   F_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E);
    run_op("multu_sh",  F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);
    run_op("div_m7d2",  F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7dm2",  F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_7d0",  F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_m8d0",  F_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF);
    run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_100",  F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);

    // mfhi held from 3 cycles after a mult: stalls until the done cycle.
    issue(F_MULTU, 32'h00010000, 32'h00030000);
    tick(); tick();
    start = 1'b1; funct = F_MFHI; srca = 32'hDEADBEEF; #1;
    chk("mfhi_stall", 64'(stall), 64'd1);
    n = 0;
    while (stall && n < 200) begin
      tick();
      n++;
    end
    chk("mfhi_stall_len", 64'(n), 64'd31);
    chk("mfhi_done", 64'(done), 64'd1);
    chk("mfhi_result", 64'(result), 64'd3);
    // second mult in the done cycle
    funct = F_MULT; srca = 32'hFFFFFFFE; srcb = 32'h00000003;
    tick();
    start = 1'b0; funct = 6'd0;
    chk("b2b_busy", 64'(busy), 64'd1);
    // an mthi presented while busy must be ignored
    start = 1'b1; funct = F_MTHI; srca = 32'h0BADF00D; #1;
    chk("busy_mthi_stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0; funct = 6'd0;
    wait_idle(n);
    chk("b2b_cycles", 64'(n), 64'd32);
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_hi", 64'(hi), 64'(32'hFFFFFFFF));
    chk("b2b_lo", 64'(lo), 64'(32'hFFFFFFFA));
    tick();

    // mthi / mtlo then read back
    issue(F_MTHI, 32'h00001234, 32'h0);
    chk("mthi_busy", 64'(busy), 64'd0);
    start = 1'b1; funct = F_MFHI; #1;
    chk("mfhi_val", 64'(result), 64'h1234);
    start = 1'b0; #1;
    issue(F_MTLO, 32'h00005678, 32'h0);
    chk("mtlo_busy", 64'(busy), 64'd0);
    start = 1'b1; funct = F_MFLO; #1;
    chk("mflo_val", 64'(result), 64'h5678);
    funct = F_ADD; #1;
    chk("other_result", 64'(result), 64'd0);
    chk("other_stall", 64'(stall), 64'd0);
    tick();
    chk("other_busy", 64'(busy), 64'd0);
    start = 1'b0; funct = 6'd0;

    // reset in the middle of a divu
    issue(F_DIVU, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1;
      tick();
    end
    chk("rst_mid_nodone", 64'(saw_done), 64'd0);
    chk("rst_mid_hi_after", 64'(hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
